// File: rtl/hood_mode_scheduler.sv
// Range-hood mode controller: power, fan levels, timed boost and timed self-clean.
// Latency: every output is registered and follows a button pulse by one clk edge.
// Backpressure: none; button pulses are acted on in the cycle they arrive.
module hood_mode_scheduler #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int BOOST_SEC = 60,   // must fit in 8 bits (<= 255)
    parameter int CLEAN_SEC = 180   // must fit in 8 bits (<= 255)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       power_btn,
    input  logic       level_go,
    input  logic [1:0] level_sel,
    input  logic       clean_btn,
    input  logic       time_out,
    output logic       if_count,
    output logic       if_clean,
    output logic [1:0] fan_level,
    output logic [2:0] state,
    output logic [7:0] remaining,
    output logic       remind
);

    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0]    BOOST_INIT = 8'(BOOST_SEC);
    localparam logic [7:0]    CLEAN_INIT = 8'(CLEAN_SEC);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_STANDBY = 3'd1,
        S_RUN     = 3'd2,
        S_BOOST   = 3'd3,
        S_CLEAN   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    fan_d;
    logic [7:0]    rem_d;
    logic          tick;
    logic          timed_d;

    // State, prescaler and every output are registered together so they move on the same edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_OFF;
            presc_q   <= '0;
            fan_level <= 2'd0;
            remaining <= 8'd0;
            if_count  <= 1'b0;
            if_clean  <= 1'b0;
            remind    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            fan_level <= fan_d;
            remaining <= rem_d;
            if_count  <= (state_d == S_RUN) || (state_d == S_BOOST);
            if_clean  <= (state_d == S_DONE);
            // Reminder is suppressed while cleaning so the lamp does not flash during the cycle
            remind    <= time_out && (state_d != S_OFF) && (state_d != S_CLEAN)
                         && (state_d != S_DONE);
        end
    end

    assign state = state_q;

    // Next-state, prescaler and next-output logic; priority is power > clean > level
    always_comb begin
        state_d = state_q;
        fan_d   = fan_level;
        rem_d   = remaining;
        tick    = 1'b0;
        presc_d = '0;

        // Prescaler only runs in the timed states; it rests at zero elsewhere,
        // so entering a timed state always starts a full tick period.
        if (state_q == S_BOOST || state_q == S_CLEAN) begin
            tick    = (presc_q == PRESC_LAST);
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        case (state_q)
            S_OFF: begin
                if (power_btn) state_d = S_STANDBY;
            end
            S_STANDBY: begin
                if (power_btn) begin
                    state_d = S_OFF;
                end else if (clean_btn) begin
                    state_d = S_CLEAN;
                    rem_d   = CLEAN_INIT;
                end else if (level_go) begin
                    case (level_sel)
                        2'd0: state_d = S_STANDBY;
                        2'd1, 2'd2: begin
                            state_d = S_RUN;
                            fan_d   = level_sel;
                        end
                        2'd3: begin
                            state_d = S_BOOST;
                            rem_d   = BOOST_INIT;
                        end
                    endcase
                end
            end
            S_RUN, S_BOOST: begin
                if (power_btn) begin
                    state_d = S_OFF;
                end else if (level_go) begin
                    case (level_sel)
                        2'd0: state_d = S_STANDBY;
                        2'd1, 2'd2: begin
                            state_d = S_RUN;
                            fan_d   = level_sel;
                        end
                        2'd3: begin
                            // Also covers a boost restart: reload and restart the tick period
                            state_d = S_BOOST;
                            rem_d   = BOOST_INIT;
                            presc_d = '0;
                        end
                    endcase
                end else if (state_q == S_BOOST && tick) begin
                    if (remaining <= 8'd1) begin
                        state_d = S_RUN;
                        fan_d   = 2'd2;
                    end else begin
                        rem_d = remaining - 8'd1;
                    end
                end
            end
            S_CLEAN: begin
                if (power_btn) begin
                    state_d = S_OFF;
                end else if (tick) begin
                    if (remaining <= 8'd1) state_d = S_DONE;
                    else                   rem_d   = remaining - 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_STANDBY;
            end
            default: begin
                state_d = S_OFF;
            end
        endcase

        // Output ranges are tied to the destination state
        timed_d = (state_d == S_BOOST) || (state_d == S_CLEAN);
        if (state_d == S_BOOST)     fan_d = 2'd3;
        else if (state_d != S_RUN)  fan_d = 2'd0;
        if (!timed_d) begin
            rem_d   = 8'd0;
            presc_d = '0;
        end
    end

endmodule

// File: doc/hood_mode_scheduler.md
Name: hood_mode_scheduler

Overview:
- Top-level mode controller for the range-hood fan and its usage-hour counter.
- Sequences power, fan levels, a timed boost level and the timed self-clean cycle.
- Drives the usage counter's count-enable and clear inputs, and consumes its time_out flag.
- Sits between the debounced button layer and the counter/display datapath.

Parameters:
TICK_DIV, 100_000_000, clk cycles per 1-second tick (bench uses 4).
BOOST_SEC, 60, boost-level duration in seconds before automatic drop to level 2.
CLEAN_SEC, 180, self-clean duration in seconds.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-low reset.
power_btn  input  1  one-cycle pulse; toggles power on/off.
level_go  input  1  one-cycle pulse; requests the level on level_sel.
level_sel  input  2  0=stop fan, 1=level 1, 2=level 2, 3=boost.
clean_btn  input  1  one-cycle pulse; requests self-clean.
time_out  input  1  usage threshold reached, from the usage counter.
if_count  output  1  usage counter enable.
if_clean  output  1  one-cycle clear pulse to the usage counter.
fan_level  output  2  0 off, 1, 2, 3 boost.
state  output  3  current FSM state, for the display.
remaining  output  8  seconds left in BOOST or CLEAN, else 0.
remind  output  1  cleaning reminder lamp.

Behaviour:
- Reset values (reset low, asynchronous): state=OFF and every output 0; tick prescaler and second counter are 0.
- Tick: the prescaler counts 0..TICK_DIV-1 and emits a one-cycle tick on the wrap. It runs only in BOOST and CLEAN. It is cleared on entry to BOOST or CLEAN, so the first tick comes TICK_DIV cycles after entry.

States (encoding) and transitions:
- OFF(0): power_btn goes to STANDBY. All other inputs are ignored.
- STANDBY(1):
  - power_btn goes to OFF.
  - clean_btn goes to CLEAN, with remaining=CLEAN_SEC.
  - level_go with level_sel 1 or 2 goes to RUN at that level.
  - level_go with level_sel 3 goes to BOOST, with remaining=BOOST_SEC.
  - level_go with level_sel 0 has no effect.
- RUN(2):
  - power_btn goes to OFF.
  - level_go with sel 0 goes to STANDBY.
  - level_go with sel 1 or 2 changes fan_level and stays in RUN.
  - level_go with sel 3 goes to BOOST.
  - clean_btn is ignored.
- BOOST(3):
  - Each tick decrements remaining.
  - On the tick where remaining goes 1→0, go to RUN with fan_level=2.
  - level_go with sel 0/1/2 exits immediately to STANDBY or RUN at that level.
  - level_go with sel 3 restarts remaining=BOOST_SEC.
  - power_btn goes to OFF.
  - clean_btn is ignored.
- CLEAN(4):
  - fan_level=0 and each tick decrements remaining.
  - On the tick where remaining goes 1→0, go to DONE.
  - power_btn aborts to OFF; no if_clean is issued.
  - level_go and clean_btn are ignored.
- DONE(5): if_clean=1 for exactly this one cycle, then STANDBY unconditionally. Inputs are ignored.

Priority within one cycle: power_btn > clean_btn > level_go.

Outputs:
- All outputs are registered and update on the same edge as the state change.
- if_count = 1 exactly when state is RUN or BOOST.
- fan_level is 0 in OFF, STANDBY, CLEAN and DONE.
- remaining is 0 outside BOOST and CLEAN. It holds CLEAN_SEC / BOOST_SEC on the entry cycle.
- remind = time_out AND state≠OFF. It is held low during CLEAN and DONE. It drops once the counter clears after if_clean.
- Width rule: remaining is 8 bits, so BOOST_SEC and CLEAN_SEC must be ≤255; larger values are illegal.
- Reset asserted mid-operation returns everything to reset values immediately. No if_clean pulse is emitted.

Test Plan (TICK_DIV=4, BOOST_SEC=3, CLEAN_SEC=5):
1. Reset low, then high; pulse power_btn → state=1, all outputs 0; pulse power_btn again → state=0.
2. In STANDBY, level_go with sel=1, then level_go with sel=2 → state=2, fan_level 1 then 2, if_count=1; level_go with sel=0 → state=1, if_count=0.
3. level_go with sel=3 from RUN → state=3, remaining=3, fan_level=3. After 12 cycles: remaining=0 → state=2, fan_level=2, if_count stays 1 throughout.
4. clean_btn in STANDBY → state=4, remaining 5,4,…,1 on each 4-cycle tick. 20 cycles after entry → state=5 with if_clean=1 for one cycle, then state=1.
5. Abort and priority:
   - CLEAN then power_btn at remaining=2 → state=0, no if_clean ever pulses.
   - power_btn, clean_btn and level_go all in the same cycle in STANDBY → state=0.
6. Hold time_out=1 in RUN → remind=1. Enter CLEAN → remind=0. Drive time_out=0 after if_clean → remind stays 0. Assert reset during BOOST → all outputs 0 asynchronously.
